// File: rtl/riscv_int_controller_mc_pkg.sv
// Shared types for the multi-line interrupt controller: privilege levels and FSM states.
package riscv_int_controller_mc_pkg;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_M = 2'b11
  } PrivLvl_t;

  typedef enum logic [1:0] {
    StIdle,
    StIrqPending,
    StIrqDone
  } int_ctrl_state_t;

endpackage

// File: rtl/riscv_int_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of the eligible vector.
module riscv_int_prio_enc #(
  parameter int unsigned N_IRQ    = 32,
  parameter int unsigned ID_WIDTH = 5
) (
  input  logic [N_IRQ-1:0]    eligible_i,
  output logic                valid_o,
  output logic [ID_WIDTH-1:0] id_o
);

  // Scan from the top so the lowest index is written last and wins.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (eligible_i[i]) begin
        valid_o = 1'b1;
        id_o    = ID_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/riscv_int_controller_mc.sv
// Multi-line interrupt controller: per-line edge/level pending, fixed priority, req/ack/kill FSM.
module riscv_int_controller_mc
  import riscv_int_controller_mc_pkg::*;
#(
  parameter int unsigned       N_IRQ       = 32,
  parameter int unsigned       ID_WIDTH    = 5,
  parameter logic [N_IRQ-1:0]  EDGE_MASK   = '0,
  parameter bit                PULP_SECURE = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_IRQ-1:0]    irq_i,
  input  logic [N_IRQ-1:0]    irq_sec_i,
  input  logic [N_IRQ-1:0]    irq_en_i,
  input  logic                m_IE_i,
  input  logic                u_IE_i,
  input  PrivLvl_t            current_priv_lvl_i,
  input  logic                ctrl_ack_i,
  input  logic                ctrl_kill_i,
  output logic                irq_req_ctrl_o,
  output logic                irq_sec_ctrl_o,
  output logic [ID_WIDTH-1:0] irq_id_ctrl_o,
  output logic [N_IRQ-1:0]    irq_pending_o,
  output logic                irq_ack_o,
  output logic [ID_WIDTH-1:0] irq_ack_id_o
);

  int_ctrl_state_t     state_q, state_d;
  logic [N_IRQ-1:0]    irq_prev_q, pend_q, pend_d;
  logic [N_IRQ-1:0]    pending, eligible, ack_clr;
  logic [ID_WIDTH-1:0] id_q, id_d, win_id;
  logic                sec_q, sec_d, win_valid, win_sec, global_en;

  riscv_int_prio_enc #(
    .N_IRQ    (N_IRQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_prio_enc (
    .eligible_i (eligible),
    .valid_o    (win_valid),
    .id_o       (win_id)
  );

  always_comb begin
    win_sec = 1'b0;
    ack_clr = '0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (win_id == ID_WIDTH'(i)) win_sec = irq_sec_i[i];
      if (id_q == ID_WIDTH'(i))   ack_clr[i] = (state_q == StIrqDone);
    end
  end

  // A fresh edge beats the ack-clear so an edge arriving in the ack cycle is kept.
  assign pend_d   = ((pend_q & ~ack_clr) | (irq_i & ~irq_prev_q)) & EDGE_MASK;
  assign pending  = (pend_q & EDGE_MASK) | (irq_i & ~EDGE_MASK);
  assign eligible = pending & irq_en_i;

  always_comb begin
    if (PULP_SECURE) begin
      global_en = ((current_priv_lvl_i == PRIV_LVL_U) && (u_IE_i || win_sec)) ||
                  ((current_priv_lvl_i == PRIV_LVL_M) && m_IE_i);
    end else begin
      global_en = m_IE_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    sec_d        = sec_q;
    irq_ack_o    = 1'b0;
    irq_ack_id_o = '0;
    unique case (state_q)
      StIdle: begin
        if (global_en && win_valid) begin
          id_d    = win_id;
          sec_d   = win_sec;
          state_d = StIrqPending;
        end
      end
      StIrqPending: begin
        if (ctrl_ack_i)       state_d = StIrqDone;
        else if (ctrl_kill_i) state_d = StIdle;
      end
      StIrqDone: begin
        irq_ack_o    = 1'b1;
        irq_ack_id_o = id_q;
        sec_d        = 1'b0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      id_q       <= '0;
      sec_q      <= 1'b0;
      pend_q     <= '0;
      irq_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      sec_q      <= sec_d;
      pend_q     <= pend_d;
      irq_prev_q <= irq_i;
    end
  end

  assign irq_req_ctrl_o = (state_q == StIrqPending);
  assign irq_sec_ctrl_o = sec_q;
  assign irq_id_ctrl_o  = id_q;
  assign irq_pending_o  = pending;

endmodule

// File: tb/tb_riscv_int_controller_mc.sv
// Directed vector bench: a non-secure and a secure instance share stimulus.
module tb_riscv_int_controller_mc;
  import riscv_int_controller_mc_pkg::*;

  localparam logic [31:0] ALL  = 32'hFFFF_FFFF;
  localparam logic [31:0] EMSK = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] irq, sec, en;
  logic        mie, uie, ack, kill;
  PrivLvl_t    priv;

  logic        req0, sec0, ackp0, req1, sec1, ackp1;
  logic [4:0]  id0, ackid0, id1, ackid1;
  logic [31:0] pend0, pend1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  riscv_int_controller_mc #(
    .N_IRQ (32), .ID_WIDTH (5), .EDGE_MASK (EMSK), .PULP_SECURE (1'b0)
  ) dut0 (
    .clk (clk), .rst_n (rst_n), .irq_i (irq), .irq_sec_i (sec), .irq_en_i (en),
    .m_IE_i (mie), .u_IE_i (uie), .current_priv_lvl_i (priv),
    .ctrl_ack_i (ack), .ctrl_kill_i (kill),
    .irq_req_ctrl_o (req0), .irq_sec_ctrl_o (sec0), .irq_id_ctrl_o (id0),
    .irq_pending_o (pend0), .irq_ack_o (ackp0), .irq_ack_id_o (ackid0)
  );

  riscv_int_controller_mc #(
    .N_IRQ (32), .ID_WIDTH (5), .EDGE_MASK (EMSK), .PULP_SECURE (1'b1)
  ) dut1 (
    .clk (clk), .rst_n (rst_n), .irq_i (irq), .irq_sec_i (sec), .irq_en_i (en),
    .m_IE_i (mie), .u_IE_i (uie), .current_priv_lvl_i (priv),
    .ctrl_ack_i (ack), .ctrl_kill_i (kill),
    .irq_req_ctrl_o (req1), .irq_sec_ctrl_o (sec1), .irq_id_ctrl_o (id1),
    .irq_pending_o (pend1), .irq_ack_o (ackp1), .irq_ack_id_o (ackid1)
  );

  typedef struct {
    logic [31:0] irq;
    logic [31:0] en;
    logic        mie, ack, kill;
    logic        req;
    logic [4:0]  id;
    logic [31:0] pend;
    logic        ackp;
    logic [4:0]  ackid;
  } vec_t;

  vec_t vecs[31];

  function automatic vec_t mk(logic [31:0] i, logic [31:0] e, logic m, logic a, logic k,
                              logic r, logic [4:0] d, logic [31:0] p, logic ap,
                              logic [4:0] ad);
    vec_t v;
    v.irq = i; v.en = e; v.mie = m; v.ack = a; v.kill = k;
    v.req = r; v.id = d; v.pend = p; v.ackp = ap; v.ackid = ad;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] s, input logic [31:0] e,
                       input logic m, input logic u, input PrivLvl_t p,
                       input logic a, input logic k);
    @(negedge clk);
    irq = i; sec = s; en = e; mie = m; uie = u; priv = p; ack = a; kill = k;
  endtask

  initial begin
    // Columns: irq, en, mie, ack, kill | req, id, pending, ack pulse, ack id
    vecs[0]  = mk(32'h08, ALL, 1, 0, 0, 1, 3, 32'h08, 0, 0);
    vecs[1]  = mk(32'h08, ALL, 1, 1, 0, 0, 3, 32'h08, 1, 3);
    vecs[2]  = mk(32'h00, ALL, 1, 0, 0, 0, 3, 32'h00, 0, 0);
    vecs[3]  = mk(32'h00, ALL, 1, 0, 0, 0, 3, 32'h00, 0, 0);
    vecs[4]  = mk(32'h84, ALL, 1, 0, 0, 1, 2, 32'h84, 0, 0);
    vecs[5]  = mk(32'h85, ALL, 1, 0, 0, 1, 2, 32'h85, 0, 0);
    vecs[6]  = mk(32'h85, ALL, 1, 1, 0, 0, 2, 32'h85, 1, 2);
    vecs[7]  = mk(32'h85, ALL, 1, 0, 0, 0, 2, 32'h85, 0, 0);
    vecs[8]  = mk(32'h85, ALL, 1, 0, 0, 1, 0, 32'h85, 0, 0);
    vecs[9]  = mk(32'h85, ALL, 1, 1, 0, 0, 0, 32'h85, 1, 0);
    vecs[10] = mk(32'h00, ALL, 1, 0, 0, 0, 0, 32'h00, 0, 0);
    vecs[11] = mk(32'h20, ALL, 0, 0, 0, 0, 0, 32'h20, 0, 0);
    vecs[12] = mk(32'h00, ALL, 0, 0, 0, 0, 0, 32'h20, 0, 0);
    vecs[13] = mk(32'h00, ALL, 1, 0, 0, 1, 5, 32'h20, 0, 0);
    vecs[14] = mk(32'h00, ALL, 1, 1, 0, 0, 5, 32'h20, 1, 5);
    vecs[15] = mk(32'h00, ALL, 1, 0, 0, 0, 5, 32'h00, 0, 0);
    vecs[16] = mk(32'h00, ALL, 1, 0, 0, 0, 5, 32'h00, 0, 0);
    vecs[17] = mk(32'h20, ALL, 1, 0, 0, 0, 5, 32'h20, 0, 0);
    vecs[18] = mk(32'h00, ALL, 1, 0, 0, 1, 5, 32'h20, 0, 0);
    vecs[19] = mk(32'h00, ALL, 1, 1, 0, 0, 5, 32'h20, 1, 5);
    vecs[20] = mk(32'h20, ALL, 1, 0, 0, 0, 5, 32'h20, 0, 0);
    vecs[21] = mk(32'h00, ALL, 1, 0, 0, 1, 5, 32'h20, 0, 0);
    vecs[22] = mk(32'h00, ALL, 1, 1, 0, 0, 5, 32'h20, 1, 5);
    vecs[23] = mk(32'h00, ALL, 1, 0, 0, 0, 5, 32'h00, 0, 0);
    vecs[24] = mk(32'h10, ALL, 1, 0, 0, 1, 4, 32'h10, 0, 0);
    vecs[25] = mk(32'h10, ALL, 1, 0, 1, 0, 4, 32'h10, 0, 0);
    vecs[26] = mk(32'h10, ALL, 1, 0, 0, 1, 4, 32'h10, 0, 0);
    vecs[27] = mk(32'h10, ALL, 1, 1, 1, 0, 4, 32'h10, 1, 4);
    vecs[28] = mk(32'h00, ALL, 1, 0, 0, 0, 4, 32'h00, 0, 0);
    vecs[29] = mk(32'h10, ~32'h10, 1, 0, 0, 0, 4, 32'h10, 0, 0);
    vecs[30] = mk(32'h00, ALL, 1, 0, 0, 0, 4, 32'h00, 0, 0);

    rst_n = 1'b0;
    irq = '0; sec = '0; en = '0; mie = 0; uie = 0; priv = PRIV_LVL_M; ack = 0; kill = 0;
    #3;
    check("rst_req0", {31'b0, req0}, 0);
    check("rst_id0", {27'b0, id0}, 0);
    check("rst_ack0", {31'b0, ackp0}, 0);
    check("rst_pend1", pend1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 31; v++) begin
      drive(vecs[v].irq, 32'h0, vecs[v].en, vecs[v].mie, 1'b0, PRIV_LVL_M,
            vecs[v].ack, vecs[v].kill);
      step();
      check($sformatf("v%0d_req0", v), {31'b0, req0}, {31'b0, vecs[v].req});
      check($sformatf("v%0d_id0", v), {27'b0, id0}, {27'b0, vecs[v].id});
      check($sformatf("v%0d_sec0", v), {31'b0, sec0}, 0);
      check($sformatf("v%0d_pend0", v), pend0, vecs[v].pend);
      check($sformatf("v%0d_ack0", v), {31'b0, ackp0}, {31'b0, vecs[v].ackp});
      check($sformatf("v%0d_ackid0", v), {27'b0, ackid0}, {27'b0, vecs[v].ackid});
      check($sformatf("v%0d_req1", v), {31'b0, req1}, {31'b0, vecs[v].req});
      check($sformatf("v%0d_id1", v), {27'b0, id1}, {27'b0, vecs[v].id});
      check($sformatf("v%0d_ack1", v), {31'b0, ackp1}, {31'b0, vecs[v].ackp});
    end

    // User mode, u_IE off: a secure line still gets through.
    drive(32'h40, 32'h40, ALL, 1, 0, PRIV_LVL_U, 0, 0);
    step();
    check("u_sec_req", {31'b0, req1}, 1);
    check("u_sec_flag", {31'b0, sec1}, 1);
    check("u_sec_id", {27'b0, id1}, 6);
    drive(32'h40, 32'h40, ALL, 1, 0, PRIV_LVL_U, 1, 0);
    step();
    check("u_sec_ack", {31'b0, ackp1}, 1);
    check("u_sec_ackid", {27'b0, ackid1}, 6);
    drive(32'h00, 32'h00, ALL, 1, 0, PRIV_LVL_U, 0, 0);
    step();
    check("u_sec_clr", {31'b0, sec1}, 0);

    // Same line without the secure bit stays blocked.
    for (int c = 0; c < 3; c++) begin
      drive(32'h40, 32'h00, ALL, 1, 0, PRIV_LVL_U, 0, 0);
      step();
      check($sformatf("u_nosec_req%0d", c), {31'b0, req1}, 0);
      check($sformatf("u_nosec_pend%0d", c), pend1, 32'h40);
    end

    drive(32'h40, 32'h00, ALL, 1, 1, PRIV_LVL_U, 0, 0);
    step();
    check("u_uie_req", {31'b0, req1}, 1);
    check("u_uie_sec", {31'b0, sec1}, 0);
    drive(32'h60, 32'h00, ALL, 1, 1, PRIV_LVL_U, 0, 0);
    step();
    check("hold_id", {27'b0, id1}, 6);
    check("hold_pend", pend1, 32'h60);
    drive(32'h00, 32'h00, ALL, 1, 1, PRIV_LVL_U, 0, 0);
    step();
    check("edge_kept", pend1, 32'h20);
    check("pre_rst_req", {31'b0, req1}, 1);

    // Asynchronous reset mid-PENDING.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req1", {31'b0, req1}, 0);
    check("arst_id1", {27'b0, id1}, 0);
    check("arst_sec1", {31'b0, sec1}, 0);
    check("arst_pend1", pend1, 0);
    check("arst_pend0", pend0, 0);
    check("arst_ack1", {31'b0, ackp1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_req1", {31'b0, req1}, 0);
    check("post_rst_pend1", pend1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
